btn_led_ctrl: RTL and testbench



---
 rtl/btn_led_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_btn_led_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: sequences the codec-fix stage (go/rdy), debounces its
// sampled button, classifies presses as short/long and drives its LED.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn          sampled button, 0 = pressed
//   rdy          codec-fix stage idle
//   go           one-cycle codec-fix start
//   led          LED drive, 1 = on
//   fix_req      single-cycle request for another codec fix
//   fix_busy     high while a fix is pending or running
//   led_mode     00 off, 01 on, 10 slow blink, 11 fast blink
//   btn_pressed  debounced level, 1 = pressed
//   btn_short    one-cycle pulse on release of a short press
//   btn_long     one-cycle pulse when a hold reaches LONG_TICKS
//
// Optional build macro: BTN_LED_CTRL_ACK_EN -- every short/long event
// inverts the LED for 16 ticks as an acknowledgement.
module btn_led_ctrl #(
  parameter int unsigned TICK_W     = 14,
  parameter int unsigned DB_TICKS   = 4,
  parameter int unsigned LONG_TICKS = 96,
  parameter int unsigned AUTO_FIX   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       rdy,
  output logic       go,
  output logic       led,
  input  logic       fix_req,
  output logic       fix_busy,
  input  logic [1:0] led_mode,
  output logic       btn_pressed,
  output logic       btn_short,
  output logic       btn_long
);

  localparam int unsigned DB_W    = 4;
  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned BLINK_W = 8;

  localparam logic [DB_W-1:0]   DB_LIMIT  = DB_W'(DB_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_GO      = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                go_q, go_d;
  logic                fix_busy_q, fix_busy_d;
  logic                pending_q, pending_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                pressed_q, pressed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                long_done_q, long_done_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                led_q, led_d;

  logic tick_c;
  logic run_c;
  logic sample_c;
  logic mode_led_c;
  logic ack_inv_c;

  assign tick_c   = &presc_q;
  assign run_c    = (state_q == ST_RUN);
  assign sample_c = ~btn;

  // Sequencer next state; a pending request is consumed when a fix starts
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | fix_req;
    go_d       = 1'b0;
    fix_busy_d = 1'b1;
    case (state_q)
      ST_BOOT: begin
        if (AUTO_FIX == 0)  state_d = ST_RUN;
        else if (rdy)       state_d = ST_GO;
      end
      ST_GO:      state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!rdy) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (rdy)  state_d = ST_RUN;
      ST_RUN:     if (pending_q && rdy) state_d = ST_GO;
      default:    state_d = ST_BOOT;
    endcase
    if ((state_d == ST_GO) && (state_q != ST_GO)) pending_d = 1'b0;
    go_d       = (state_d == ST_GO);
    fix_busy_d = (state_d != ST_RUN);
  end

  // Debounce and press classification; frozen outside RUN (btn is stale)
  always_comb begin
    presc_d     = presc_q + TICK_W'(1);
    db_cnt_d    = db_cnt_q;
    pressed_d   = pressed_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    if (tick_c && run_c) begin
      if (sample_c == pressed_q) begin
        db_cnt_d = '0;
      end else if ((db_cnt_q + DB_W'(1)) == DB_LIMIT) begin
        pressed_d = ~pressed_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end

      if (!pressed_q && pressed_d) begin
        hold_d      = '0;
        long_done_d = 1'b0;
      end else if (pressed_q && !pressed_d) begin
        short_d = ~long_done_q;
      end else if (pressed_q && (hold_q != HOLD_MAX)) begin
        hold_d = hold_q + HOLD_W'(1);
        if ((hold_q + HOLD_W'(1)) == HOLD_LONG) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end
    end
  end

`ifdef BTN_LED_CTRL_ACK_EN
  localparam int unsigned ACK_W = 8;
  localparam logic [ACK_W-1:0] ACK_RELOAD = ACK_W'(16);

  logic [ACK_W-1:0] ack_q, ack_d;

  // Acknowledge counter: reload on any event, count down per tick
  always_comb begin
    ack_d = ack_q;
    if (short_d || long_d)               ack_d = ACK_RELOAD;
    else if (tick_c && (ack_q != '0))    ack_d = ack_q - ACK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= '0;
    else        ack_q <= ack_d;
  end

  assign ack_inv_c = (ack_q != '0);
`else
  assign ack_inv_c = 1'b0;
`endif

  // LED source and blink counter; led holds its value outside RUN
  always_comb begin
    blink_d = tick_c ? (blink_q + BLINK_W'(1)) : blink_q;
    case (led_mode)
      2'b00:   mode_led_c = 1'b0;
      2'b01:   mode_led_c = 1'b1;
      2'b10:   mode_led_c = blink_q[7];
      default: mode_led_c = blink_q[5];
    endcase
    led_d = led_q;
    if (run_c) led_d = mode_led_c ^ ack_inv_c;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      go_q        <= 1'b0;
      fix_busy_q  <= 1'b1;
      pending_q   <= 1'b0;
      presc_q     <= '0;
      db_cnt_q    <= '0;
      pressed_q   <= 1'b0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      blink_q     <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      fix_busy_q  <= fix_busy_d;
      pending_q   <= pending_d;
      presc_q     <= presc_d;
      db_cnt_q    <= db_cnt_d;
      pressed_q   <= pressed_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      short_q     <= short_d;
      long_q      <= long_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign go          = go_q;
  assign fix_busy    = fix_busy_q;
  assign btn_pressed = pressed_q;
  assign btn_short   = short_q;
  assign btn_long    = long_q;
  assign led         = led_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Bench for btn_led_ctrl: randomized button presses checked through a
// scoreboard of expected go/short/long events (with cycle windows), plus
// direct checks of fix_busy, debounced level and LED.
module tb_btn_led_ctrl;

  localparam int TPC  = 4;   // clk cycles per tick (TICK_W = 2)
  localparam int LONG = 10;

  logic       clk = 1'b0;
  logic       rst_n, btn, rdy, fix_req;
  logic       go, led, fix_busy, btn_pressed, btn_short, btn_long;
  logic [1:0] led_mode;

  int tests = 0;
  int fails = 0;
  int cyc;
  int go_cnt = 0;
  int go_cyc = 0;
  bit prev_go = 1'b0;

  typedef struct {
    int kind;   // 0 short, 1 long, 2 go
    int lo;
    int hi;
  } exp_t;

  exp_t go_q[$];
  exp_t btn_q[$];

  btn_led_ctrl #(
    .TICK_W(2), .DB_TICKS(3), .LONG_TICKS(10), .AUTO_FIX(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .rdy(rdy), .go(go), .led(led),
    .fix_req(fix_req), .fix_busy(fix_busy), .led_mode(led_mode),
    .btn_pressed(btn_pressed), .btn_short(btn_short), .btn_long(btn_long)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_go(input int lo, input int hi);
    exp_t e;
    e.kind = 2; e.lo = lo; e.hi = hi;
    go_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected LED from the tick count: blink counter = ticks completed so far
  function automatic logic exp_led(input logic [1:0] m, input int k);
    int b;
    b = (k - 1) / TPC;
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return ((b / 128) % 2) == 1;
      default: return ((b / 32) % 2) == 1;
    endcase
  endfunction

  // Press model: hold btn low for L ticks then high for G ticks (G >= 3).
  // Sample s (0-based) lands on edge c0 + 4*(s+1). Rise at s=2, release at
  // s=L+2, held ticks counted from s=3 to s=L+1, long reached at s=12.
  task automatic press(input int L, input int G);
    int   c0;
    exp_t e;
    c0 = cyc;
    btn = 1'b0;
    if (L >= 3) begin
      e.kind = (L - 1 >= LONG) ? 1 : 0;
      e.lo   = (e.kind == 1) ? c0 + TPC * (LONG + 3) : c0 + TPC * (L + 3);
      e.hi   = e.lo;
      btn_q.push_back(e);
    end
    for (int i = 1; i <= TPC * L; i++) begin
      step();
      if (i == 11 || i == 12)
        check(btn_pressed == (i == 12), "pressed_rise", int'(btn_pressed), int'(i == 12));
    end
    btn = 1'b1;
    repeat (TPC * G) step();
    check(btn_pressed == 1'b0, "pressed_release", int'(btn_pressed), 0);
  endtask

  task automatic wait_go(input int target, input int max, input bit chk_p);
    for (int i = 0; i < max && go_cnt < target; i++) begin
      step();
      if (chk_p) check(btn_pressed == 1'b0, "pressed_frozen", int'(btn_pressed), 0);
    end
    check(go_cnt >= target, "go_timeout", go_cnt, target);
  endtask

  task automatic wait_busy_low(input int max, input bit chk_p);
    for (int i = 0; i < max && fix_busy; i++) begin
      step();
      if (chk_p) check(btn_pressed == 1'b0, "pressed_frozen", int'(btn_pressed), 0);
    end
    check(fix_busy == 1'b0, "busy_timeout", int'(fix_busy), 0);
  endtask

  // Scoreboard monitor: pops expected events whenever the DUT pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_go = 1'b0;
      end else begin
        if (go) begin
          go_cnt++;
          go_cyc = cyc;
          check(!prev_go, "go_width", 2, 1);
          if (go_q.size() == 0) check(1'b0, "go_unexpected", cyc, -1);
          else begin
            e = go_q.pop_front();
            check(cyc >= e.lo && cyc <= e.hi, "go_cycle", cyc, e.lo);
          end
        end
        prev_go = go;
        if (btn_short && btn_long) begin
          check(1'b0, "short_long_same_cycle", 1, 0);
        end else if (btn_short || btn_long) begin
          if (btn_q.size() == 0) check(1'b0, "btn_event_unexpected", cyc, -1);
          else begin
            e = btn_q.pop_front();
            check(int'(btn_long) == e.kind, "btn_event_kind", int'(btn_long), e.kind);
            check(cyc == e.lo, "btn_event_cycle", cyc, e.lo);
          end
        end
      end
    end
  end

  // Codec-stage model: after each go, drop rdy for 40 cycles then raise it
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && go) begin
        step();
        rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
          step();
          check(fix_busy == 1'b1, "busy_during_fix", int'(fix_busy), 1);
        end
        rdy = 1'b1;
        step();
        check(fix_busy == 1'b0, "busy_drop", int'(fix_busy), 0);
      end
    end
  end

  initial begin
    #400000;
    check(1'b0, "watchdog", cyc, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int c, e, g;
    rst_n = 1'b1; btn = 1'b1; rdy = 1'b1; fix_req = 1'b0; led_mode = 2'b00;
    #2 rst_n = 1'b0;
    #10;
    check(go == 1'b0,          "rst_go",       int'(go), 0);
    check(led == 1'b0,         "rst_led",      int'(led), 0);
    check(fix_busy == 1'b1,    "rst_busy",     int'(fix_busy), 1);
    check(btn_pressed == 1'b0, "rst_pressed",  int'(btn_pressed), 0);
    check(btn_short == 1'b0,   "rst_short",    int'(btn_short), 0);
    check(btn_long == 1'b0,    "rst_long",     int'(btn_long), 0);
    push_go(1, 2);
    #10 rst_n = 1'b1;

    // Boot fix
    wait_go(1, 10, 1'b0);
    wait_busy_low(100, 1'b0);
    repeat (10) step();
    check(go_cnt == 1, "boot_single_go", go_cnt, 1);

    // Requested fix, then two coalesced requests during WAIT_HI; btn held
    // low while busy must not move the debouncer
    step();
    c = cyc;
    fix_req = 1'b1;
    push_go(c + 1, c + 4);
    step();
    fix_req = 1'b0;
    wait_go(2, 20, 1'b0);
    e = go_cyc;
    btn = 1'b0;
    push_go(e + 41, e + 50);
    while (cyc < e + 10) begin
      step();
      check(btn_pressed == 1'b0, "pressed_frozen", int'(btn_pressed), 0);
    end
    fix_req = 1'b1; step(); fix_req = 1'b0;
    while (cyc < e + 20) begin
      step();
      check(btn_pressed == 1'b0, "pressed_frozen", int'(btn_pressed), 0);
    end
    fix_req = 1'b1; step(); fix_req = 1'b0;
    wait_go(3, 60, 1'b1);
    wait_busy_low(100, 1'b1);
    btn = 1'b1;
    repeat (10) step();
    check(btn_pressed == 1'b0, "pressed_after_freeze", int'(btn_pressed), 0);
    check(go_cnt == 3, "extra_go_count", go_cnt, 3);

    // Button presses aligned to tick boundaries
    for (int i = 0; i < TPC && (cyc % TPC) != 0; i++) step();
    press(20, 6);
    press(15, 6);
    press(2, 6);
    press(10, 6);
    press(11, 6);
    press(3, 4);
    for (int i = 0; i < 12; i++)
      press(int'($urandom_range(1, 16)), int'($urandom_range(4, 8)));

    // Short press with LED on: inverted for 16 ticks only with the ack option
    led_mode = 2'b01;
    c = cyc;
    press(4, 4);
`ifdef BTN_LED_CTRL_ACK_EN
    check(led == 1'b0, "ack_led_inverted", int'(led), 0);
`else
    check(led == 1'b1, "led_on_after_press", int'(led), 1);
`endif
    while (cyc < c + 100) step();
    check(led == 1'b1, "led_on_restored", int'(led), 1);

    // LED modes against the tick-count model
    for (int m = 0; m < 4; m++) begin
      led_mode = 2'(m);
      for (int i = 0; i < ((m == 2) ? 1100 : (m == 3) ? 600 : 20); i++) begin
        step();
        check(led == exp_led(led_mode, cyc), "led_mode_value", int'(led),
              int'(exp_led(led_mode, cyc)));
      end
    end

    // Asynchronous reset while the fast blink has led on
    for (int i = 0; i < 300 && !led; i++) step();
    check(led == 1'b1, "led_before_reset", int'(led), 1);
    #2 rst_n = 1'b0;
    #1;
    check(led == 1'b0,         "async_rst_led",     int'(led), 0);
    check(go == 1'b0,          "async_rst_go",      int'(go), 0);
    check(fix_busy == 1'b1,    "async_rst_busy",    int'(fix_busy), 1);
    check(btn_pressed == 1'b0, "async_rst_pressed", int'(btn_pressed), 0);
    #10;
    g = go_cnt;
    push_go(1, 2);
    @(negedge clk) rst_n = 1'b1;
    wait_go(g + 1, 10, 1'b0);
    wait_busy_low(100, 1'b0);
    repeat (10) step();

    check(go_q.size() == 0,  "go_queue_empty",  go_q.size(), 0);
    check(btn_q.size() == 0, "btn_queue_empty", btn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
